// File: rtl/fighter_sprite_ctrl.sv
// ---------------------------------------------------------------------------
// fighter_sprite_ctrl
//
// Per-pixel sequencer for one fighter sprite. It maps the VGA scan position to
// a sprite ROM address, with optional horizontal mirroring. It passes the
// returned colour index to the fighter palette and keys out the transparent
// index. It also runs the hit-flash FSM, which whitens the sprite for a fixed
// number of frames.
//
// The pipeline has a latency of exactly 2 cycles and accepts one pixel per
// cycle:
//   cycle N   : bounds check and rom_addr (combinational from the inputs)
//   cycle N+1 : rom_index returns and goes straight out as pal_index; the
//               palette answers combinationally
//   cycle N+2 : out_* are valid from the output register
//
// Ports
//   Clk, Reset               pixel clock, synchronous active-high reset
//   pix_valid, draw_x/y      scan position of the current visible pixel
//   frame_start              one-cycle pulse per frame (drives flash timing)
//   pos_x/y, facing_left     sprite placement and mirroring, sampled per pixel
//   hit                      starts or restarts the flash sequence
//   rom_addr / rom_index     synchronous sprite ROM, 1-cycle read latency
//   pal_index / pal_rgb      combinational palette lookup
//   out_valid, out_opaque,
//   out_red/green/blue       final pixel, 2 cycles after the input pixel
//   flashing                 flash FSM is not idle
// ---------------------------------------------------------------------------
module fighter_sprite_ctrl #(
    parameter int SPR_W         = 64,
    parameter int SPR_H         = 96,
    parameter int ADDR_W        = 13,
    parameter int TRANSP_INDEX  = 0,
    parameter int FLASH_FRAMES  = 4,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_valid,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    input  logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_index,
    output logic [3:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic              out_valid,
    output logic              out_opaque,
    output logic [3:0]        out_red,
    output logic [3:0]        out_green,
    output logic [3:0]        out_blue,
    output logic              flashing
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
    localparam int TC_W  = $clog2(FLASH_TOGGLES + 1);

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TC_W-1:0]   tog_cnt_q, tog_cnt_d;
    logic              flashing_q, flashing_d;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_inbox_q, s1_inbox_d;
    logic              s1_flash_q, s1_flash_d;

    logic              out_valid_q, out_valid_d;
    logic              out_opaque_q, out_opaque_d;
    logic [11:0]       out_rgb_q, out_rgb_d;

    logic [10:0]       x_end, y_end;
    logic              in_box;
    logic [COL_W-1:0]  dx, col;
    logic [9:0]        dy;

    // Stage 0: bounds check and ROM address.
    always_comb begin
        // The end bounds are 11 bits wide, so a sprite near column or row 1023
        // does not wrap back to zero.
        x_end  = {1'b0, pos_x} + 11'(SPR_W);
        y_end  = {1'b0, pos_y} + 11'(SPR_H);
        in_box = pix_valid
               & ({1'b0, draw_x} >= {1'b0, pos_x}) & ({1'b0, draw_x} < x_end)
               & ({1'b0, draw_y} >= {1'b0, pos_y}) & ({1'b0, draw_y} < y_end);
        dx     = COL_W'(draw_x - pos_x);
        dy     = draw_y - pos_y;
        // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse of dx.
        col    = facing_left ? ~dx : dx;
        rom_addr = '0;
        if (in_box && !Reset) begin
            rom_addr = (ADDR_W'(dy) << COL_W) | ADDR_W'(col);
        end
    end

    // Stage 1: the ROM data goes straight to the palette.
    assign pal_index = Reset ? 4'd0 : rom_index;

    // Pipeline and output register inputs.
    always_comb begin
        s1_valid_d   = pix_valid;
        s1_inbox_d   = in_box;
        s1_flash_d   = (state_q == FLASH_ON);
        out_valid_d  = s1_valid_q;
        out_opaque_d = s1_inbox_q & (rom_index != 4'(TRANSP_INDEX));
        out_rgb_d    = 12'h000;
        if (out_opaque_d) begin
            out_rgb_d = s1_flash_q ? 12'hFFF : {pal_red, pal_green, pal_blue};
        end
    end

    // Flash FSM: next state and counters. A hit always restarts the sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        if (hit) begin
            state_d     = FLASH_ON;
            frame_cnt_d = '0;
            tog_cnt_d   = '0;
        end else if (frame_start && state_q != IDLE) begin
            if (frame_cnt_q == FC_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_d = '0;
                tog_cnt_d   = tog_cnt_q + 1'b1;
                if (tog_cnt_d == TC_W'(FLASH_TOGGLES)) begin
                    state_d   = IDLE;
                    tog_cnt_d = '0;
                end else begin
                    state_d = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        flashing_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge. Reset clears the whole
    // pipeline, which drops in-flight pixels.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            tog_cnt_q    <= '0;
            flashing_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_inbox_q   <= 1'b0;
            s1_flash_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opaque_q <= 1'b0;
            out_rgb_q    <= 12'h000;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            flashing_q   <= flashing_d;
            s1_valid_q   <= s1_valid_d;
            s1_inbox_q   <= s1_inbox_d;
            s1_flash_q   <= s1_flash_d;
            out_valid_q  <= out_valid_d;
            out_opaque_q <= out_opaque_d;
            out_rgb_q    <= out_rgb_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opaque = out_opaque_q;
    assign out_red    = out_rgb_q[11:8];
    assign out_green  = out_rgb_q[7:4];
    assign out_blue   = out_rgb_q[3:0];
    assign flashing   = flashing_q;

endmodule

// File: tb/tb_fighter_sprite_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fighter_sprite_ctrl
//
// Scoreboard bench for fighter_sprite_ctrl. The stimulus tasks drive one
// pixel per cycle. For each visible pixel they push the expected output onto
// a queue, computed by a behavioural model (ROM/palette arrays, plain
// arithmetic for the bounds, and a frames-since-hit count for the flash).
// A monitor on the falling edge pops and compares whenever out_valid is
// high, and checks that bubbles are all zero.
// ---------------------------------------------------------------------------
module tb_fighter_sprite_ctrl;

    localparam int SPR_W = 64;
    localparam int SPR_H = 96;
    localparam int ADDR_W = 13;
    localparam int FF = 4;
    localparam int FT = 6;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              pix_valid;
    logic [9:0]        draw_x, draw_y, pos_x, pos_y;
    logic              frame_start, facing_left, hit;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_index;
    logic [3:0]        pal_index, pal_red, pal_green, pal_blue;
    logic              out_valid, out_opaque, flashing;
    logic [3:0]        out_red, out_green, out_blue;

    always #5 Clk = ~Clk;

    fighter_sprite_ctrl dut (
        .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid),
        .draw_x(draw_x), .draw_y(draw_y), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .hit(hit),
        .rom_addr(rom_addr), .rom_index(rom_index), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .out_valid(out_valid), .out_opaque(out_opaque),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .flashing(flashing)
    );

    // Environment: synchronous ROM and combinational palette.
    logic [3:0]  rom_mem [0:(1<<ADDR_W)-1];
    logic [11:0] pal [0:15];

    always @(posedge Clk) rom_index <= rom_mem[rom_addr];
    assign {pal_red, pal_green, pal_blue} = pal[pal_index];

    typedef struct {
        logic        opaque;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    bit   last_pushed = 0;
    bit   m_active = 0;
    int   m_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented pixel against the scoreboard.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pixel: got out_valid=1 expected no pixel at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_opaque", 32'(out_opaque), 32'(e.opaque));
                    check("out_rgb", 32'({out_red, out_green, out_blue}), 32'(e.rgb));
                end
            end else begin
                check("bubble", 32'({out_valid, out_opaque, out_red, out_green, out_blue}), 32'h0);
            end
        end
    end

    // One cycle of stimulus plus model update.
    task automatic step(input bit rst, input bit pv, input int dxv, input int dyv,
                        input int px, input int py, input bit fl, input bit h, input bit fs);
        int   addr;
        bit   inb, flash_on, opq;
        exp_t e;
        exp_t dropped;
        @(posedge Clk);
        #1;
        Reset       = rst;
        pix_valid   = pv;
        draw_x      = 10'(dxv);
        draw_y      = 10'(dyv);
        pos_x       = 10'(px);
        pos_y       = 10'(py);
        facing_left = fl;
        hit         = h;
        frame_start = fs;
        #1;
        check("flashing", 32'(flashing), 32'(m_active));
        if (rst) begin
            check("rom_addr_in_reset", 32'(rom_addr), 32'h0);
            if (last_pushed) dropped = exp_q.pop_back();
            last_pushed = 0;
            m_active = 0;
            m_frames = 0;
        end else begin
            inb  = pv && dxv >= px && dxv < px + SPR_W && dyv >= py && dyv < py + SPR_H;
            addr = inb ? (dyv - py) * SPR_W + (fl ? SPR_W - 1 - (dxv - px) : dxv - px) : 0;
            check("rom_addr", 32'(rom_addr), 32'(addr));
            if (pv) begin
                flash_on = m_active && ((m_frames / FF) % 2 == 0);
                opq      = inb && (rom_mem[addr] != 4'd0);
                e.opaque = opq;
                e.rgb    = !opq ? 12'h000 : (flash_on ? 12'hFFF : pal[rom_mem[addr]]);
                exp_q.push_back(e);
            end
            last_pushed = pv;
            if (h) begin
                m_active = 1;
                m_frames = 0;
            end else if (fs && m_active) begin
                m_frames++;
                if (m_frames == FF * FT) m_active = 0;
            end
        end
    endtask

    task automatic rand_step(input bit h, input bit fs);
        int px, py, dxv, dyv;
        px  = $urandom_range(0, 1023);
        py  = $urandom_range(0, 1023);
        dxv = px + $urandom_range(0, 79) - 8;
        dyv = py + $urandom_range(0, 111) - 8;
        if (dxv < 0 || dxv > 1023) dxv = $urandom_range(0, 1023);
        if (dyv < 0 || dyv > 1023) dyv = $urandom_range(0, 1023);
        step(0, $urandom_range(0, 9) < 8, dxv, dyv, px, py, 1'($urandom_range(0, 1)), h, fs);
    endtask

    // One frame of the flash timeline: two opaque pixels, then frame_start.
    task automatic frame_steps(input int n);
        for (int f = 0; f < n; f++) begin
            step(0, 1, 110, 60, 100, 50, 0, 0, 0);
            step(0, 1, 112, 61, 100, 50, 0, 0, 0);
            step(0, 1, 110, 60, 100, 50, 0, 0, 1);
        end
    endtask

    initial begin
        Reset = 1'b1; pix_valid = 0; draw_x = 0; draw_y = 0; pos_x = 0; pos_y = 0;
        facing_left = 0; hit = 0; frame_start = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
        rom_mem[650] = 4'd5;
        rom_mem[693] = 4'd0;
        rom_mem[10 * 64 + 12] = 4'd9;
        rom_mem[11 * 64 + 12] = 4'd7;
        pal[5] = 12'h126;

        // Reset state
        step(1, 1, 110, 60, 100, 50, 0, 0, 0);
        step(1, 1, 110, 60, 100, 50, 0, 0, 0);
        check("reset_outputs",
              32'({out_valid, out_opaque, out_red, out_green, out_blue, flashing}), 32'h0);
        mon_en = 1;

        // Addressing, mirror + transparency, bounds
        step(0, 1, 110, 60, 100, 50, 0, 0, 0);
        check("addr_650", 32'(rom_addr), 32'd650);
        step(0, 1, 110, 60, 100, 50, 1, 0, 0);
        check("addr_693", 32'(rom_addr), 32'd693);
        step(0, 1, 1020, 5, 1000, 0, 0, 0, 0);
        step(0, 1, 999, 5, 1000, 0, 0, 0, 0);
        step(0, 1, 164, 50, 100, 50, 0, 0, 0);
        step(0, 1, 20, 1023, 0, 1000, 1, 0, 0);
        step(0, 0, 110, 60, 100, 50, 0, 0, 0);

        // Random traffic with occasional hits and frame starts
        for (int i = 0; i < 400; i++)
            rand_step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10);

        // Full flash timeline from idle
        for (int i = 0; i < 30; i++) step(0, 1, 110, 60, 100, 50, 0, 0, 1);
        step(0, 1, 110, 60, 100, 50, 0, 1, 0);
        frame_steps(24);
        frame_steps(2);

        // Restart: hit together with frame_start at tog_cnt 3
        step(0, 1, 110, 60, 100, 50, 0, 1, 0);
        frame_steps(12);
        step(0, 1, 110, 60, 100, 50, 0, 1, 1);
        frame_steps(24);
        frame_steps(1);

        // Reset mid-stream during a flash
        step(0, 1, 110, 60, 100, 50, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 110 + i, 60, 100, 50, 0, 0, 0);
        step(1, 1, 110, 60, 100, 50, 0, 0, 0);
        step(0, 1, 111, 60, 100, 50, 0, 0, 0);
        check("after_reset_1",
              32'({out_valid, out_opaque, out_red, out_green, out_blue, flashing}), 32'h0);
        step(0, 1, 112, 60, 100, 50, 0, 0, 0);
        check("after_reset_2", 32'(out_valid), 32'h0);
        for (int i = 0; i < 20; i++) rand_step(0, 0);

        // Drain
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
